// File: rtl/corr_matrix_collect.sv
// corr_matrix_collect: gathers one frame of NUM_ENTRIES complex correlation
// results from the correlator, then replays them in order to a downstream
// consumer under a valid/ready handshake.
module corr_matrix_collect #(
    parameter int DATA_WIDTH_BITS = 12,
    parameter int NUM_ENTRIES     = 10,
    localparam int RW    = 2*DATA_WIDTH_BITS + 1,
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [RW-1:0]    i_r,
    input  logic [RW-1:0]    i_c,
    input  logic             i_valid,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic [RW-1:0]    o_r,
    output logic [RW-1:0]    o_c,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid,
    output logic             o_last,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    typedef enum logic {COLLECT = 1'b0, READOUT = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             we;

    // {imag, real} per slot; never cleared so flush/frame end only touch indices
    logic [2*RW-1:0]  mem [NUM_ENTRIES];
    logic [2*RW-1:0]  rd_word;

    // state, indices, count and sticky overflow; async reset abandons the frame
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= COLLECT;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // next-state logic; flush overrides everything, including a same-cycle write
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        if (i_flush) begin
            state_d  = COLLECT;
            wr_idx_d = '0;
            rd_idx_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (i_valid) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_d = '0;
                            state_d  = READOUT;
                        end else begin
                            wr_idx_d = wr_idx_q + IDX_W'(1);
                        end
                    end
                end
                READOUT: begin
                    // results arriving while the frame is still being drained are lost
                    if (i_valid) ovf_d = 1'b1;
                    if (i_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_d  = COLLECT;
                            rd_idx_d = '0;
                            cnt_d    = '0;
                        end else begin
                            rd_idx_d = rd_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // storage write port, bit-exact copy of the input pair
    always_ff @(posedge i_clk) begin
        if (we) mem[wr_idx_q] <= {i_c, i_r};
    end

    // output view: the slot at rd_idx while reading out, zeros otherwise
    always_comb begin
        rd_word    = mem[rd_idx_q];
        o_valid    = (state_q == READOUT);
        o_last     = o_valid && (rd_idx_q == LAST_IDX);
        o_r        = o_valid ? rd_word[RW-1:0]    : '0;
        o_c        = o_valid ? rd_word[2*RW-1:RW] : '0;
        o_idx      = o_valid ? rd_idx_q           : '0;
        o_count    = cnt_q;
        o_overflow = ovf_q;
    end

endmodule

// File: tb/tb_corr_matrix_collect.sv
// Directed bench for corr_matrix_collect: frame collect/readout, stall,
// overflow, flush, async reset abort and full-scale bit-exactness.
module tb_corr_matrix_collect;

    localparam int DW = 12;
    localparam int NE = 10;
    localparam int RW = 2*DW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] i_r, i_c;
    logic          i_valid, i_flush, i_ready;
    logic [RW-1:0] o_r, o_c;
    logic [3:0]    o_idx;
    logic          o_valid, o_last;
    logic [3:0]    o_count;
    logic          o_overflow;

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] exp_r [NE];
    logic [RW-1:0] exp_c [NE];

    corr_matrix_collect #(.DATA_WIDTH_BITS(DW), .NUM_ENTRIES(NE)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_r(i_r), .i_c(i_c),
        .i_valid(i_valid), .i_flush(i_flush), .i_ready(i_ready),
        .o_r(o_r), .o_c(o_c), .o_idx(o_idx), .o_valid(o_valid),
        .o_last(o_last), .o_count(o_count), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // back-to-back writes; entry neg_slot gets full-scale negative in both parts
    task automatic write_frame(input int base, input int neg_slot);
        for (int k = 0; k < NE; k++) begin
            if (k == neg_slot) begin
                exp_r[k] = 25'h1000000;
                exp_c[k] = 25'h1000000;
            end else begin
                exp_r[k] = RW'(base + k);
                exp_c[k] = RW'(-(base + k));
            end
            i_r = exp_r[k]; i_c = exp_c[k]; i_valid = 1'b1;
            tick();
            chk("wr_count", o_count, 64'(k + 1));
            if (k < NE-1) chk("wr_valid_low", o_valid, 0);
        end
        i_valid = 1'b0;
        i_r = '0; i_c = '0;
    endtask

    // drain a frame with ready high; optional 3-cycle stall with two dropped inputs
    task automatic read_frame(input int stall_idx);
        i_ready = 1'b1;
        for (int k = 0; k < NE; k++) begin
            if (k == stall_idx) begin
                i_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    i_valid = (s < 2);
                    i_r = 25'h0ABCDE; i_c = 25'h1FFFFF;
                    chk("stall_idx", o_idx, 64'(k));
                    chk("stall_r", o_r, exp_r[k]);
                    chk("stall_c", o_c, exp_c[k]);
                    tick();
                end
                i_valid = 1'b0;
                chk("ovf_set", o_overflow, 1);
                i_ready = 1'b1;
            end
            chk("rd_valid", o_valid, 1);
            chk("rd_idx", o_idx, 64'(k));
            chk("rd_r", o_r, exp_r[k]);
            chk("rd_c", o_c, exp_c[k]);
            chk("rd_last", o_last, (k == NE-1));
            tick();
        end
        chk("end_valid", o_valid, 0);
        chk("end_count", o_count, 0);
        chk("end_last", o_last, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_r = '0; i_c = '0;
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        #12;
        // reset state
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_r", o_r, 0);
        chk("rst_idx", o_idx, 0);
        rst_n = 1'b1;
        tick();

        // basic frame: r=k, c=-k
        write_frame(0, -1);
        chk("f1_first_valid", o_valid, 1);
        chk("f1_count_full", o_count, 10);
        read_frame(-1);
        chk("f1_ovf", o_overflow, 0);

        // stall at idx 4 with two dropped inputs
        write_frame(100, -1);
        read_frame(4);
        chk("ovf_sticky", o_overflow, 1);
        i_r = 25'h5; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("ovf_next_frame", o_overflow, 1);
        chk("nf_count", o_count, 1);

        // flush with coincident write
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_count0", o_count, 0);
        for (int k = 0; k < 6; k++) begin
            i_r = RW'(200 + k); i_c = RW'(k); i_valid = 1'b1;
            tick();
        end
        chk("pre_flush_count", o_count, 6);
        i_r = 25'h1234; i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_count", o_count, 0);
        chk("flush_ovf", o_overflow, 0);
        chk("flush_valid", o_valid, 0);
        write_frame(300, -1);
        read_frame(-1);

        // async reset mid-readout at idx 3
        write_frame(400, -1);
        i_ready = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_idx", o_idx, 3);
        chk("pre_rst_r", o_r, 403);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_r", o_r, 0);
        chk("arst_c", o_c, 0);
        chk("arst_idx", o_idx, 0);
        chk("arst_count", o_count, 0);
        chk("arst_last", o_last, 0);
        tick();
        chk("arst_hold", o_valid, 0);
        rst_n = 1'b1;
        i_ready = 1'b0;
        tick();
        write_frame(500, -1);
        read_frame(-1);

        // full-scale negative, bit-exact
        write_frame(600, 5);
        read_frame(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
